// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side adapter for the synchronous FIFO. Pops words through the FIFO's
// rd_en / rd_data / empty port (one cycle registered read latency) and
// re-presents them as a valid/ready stream through a 2-entry skid buffer,
// sustaining one word per cycle. m_last marks the final beat of each burst of
// burst_len beats.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         asynchronous active-low reset
//   fifo_rd_en    pop request to the FIFO (combinational)
//   fifo_rd_data  FIFO read data, valid the cycle after a pop
//   fifo_empty    FIFO empty flag
//   m_valid       stream data valid
//   m_ready       downstream ready
//   m_data        stream data (head of the skid buffer)
//   m_last        final beat of the current burst
//   flush         synchronous discard of buffered and in-flight words
//   busy          words buffered or a pop in flight
//
// Handshake: a beat transfers on every rising clk edge where m_valid and
// m_ready are both high. Once m_valid rises it stays high, with m_data and
// m_last stable, until that transfer happens (or flush / reset drops it).
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int data_width = 100,
    parameter int burst_len  = 4,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [data_width-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic                  m_last,
    input  logic                  flush,
    output logic                  busy
);

    localparam logic [cnt_width-1:0] last_beat = cnt_width'(burst_len - 1);

    logic [1:0]            occ;       // skid-buffer entries in use (0..2)
    logic                  inflight;  // a pop was issued last cycle
    logic                  run;       // low from reset until the first clk edge after release
    logic [data_width-1:0] buf0;      // head entry
    logic [data_width-1:0] buf1;
    logic [cnt_width-1:0]  beat_cnt;

    logic       pop;
    logic       capture;
    logic [1:0] occ_after_pop;
    logic [1:0] occ_next;
    logic [2:0] fill;

    assign pop     = m_valid & m_ready;
    // The word returning during a flush cycle is dropped on the floor.
    assign capture = inflight & ~flush;

    // pop implies occ >= 1, so this never wraps.
    assign occ_after_pop = occ - {1'b0, pop};
    assign occ_next      = occ_after_pop + {1'b0, capture};

    // Entries that will be committed once this cycle's pop leaves; a new pop
    // is only safe if its word will still have a free slot when it lands.
    assign fill = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign fifo_rd_en = run & ~fifo_empty & ~flush & (fill < 3'd2);

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf0;
    assign m_last  = m_valid & (beat_cnt == last_beat);
    assign busy    = (occ != 2'd0) | inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            beat_cnt <= '0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= fifo_rd_en;

            // Head advances when the head leaves while a second word waits.
            if (pop && (occ == 2'd2)) begin
                buf0 <= buf1;
            end

            // A landing word goes to the first slot that is free after the
            // pop; at occ=2 with a pop that is buf1, behind the shifted head.
            if (capture) begin
                if (occ_after_pop == 2'd0) begin
                    buf0 <= fifo_rd_data;
                end else begin
                    buf1 <= fifo_rd_data;
                end
            end

            if (flush) begin
                // A handshake in this cycle is still delivered, but the burst
                // position restarts from zero regardless.
                occ      <= 2'd0;
                beat_cnt <= '0;
            end else begin
                occ <= occ_next;
                if (pop) begin
                    beat_cnt <= (beat_cnt == last_beat) ? '0 : beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Directed bench for fifo_stream_reader with the default parameters
// (data_width=100, burst_len=4). A behavioural FIFO with one cycle read
// latency feeds the DUT. Per-cycle tables cover streaming and backpressure;
// hand-written sequences cover alternating ready, flush and a mid-burst
// asynchronous reset. Every handshake is also checked against an expected
// queue of {word, last}.
//
// Cycle layout (period 10): inputs change at edge+1, outputs are checked at
// edge+5, the FIFO samples fifo_rd_en at edge+9 and returns data at edge+11.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int W = 100;

  logic         clk;
  logic         rst_n;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_rd_data;
  logic         fifo_empty;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         flush;
  logic         busy;

  fifo_stream_reader #(
    .data_width (W),
    .burst_len  (4),
    .cnt_width  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .flush        (flush),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  typedef struct {
    logic       m_ready;
    logic       flush;
    logic       rd_en;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       busy;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  logic [W-1:0] junk_word;

  int n_cmp;
  int n_bad;
  int pop_count;
  int hs_count;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic f, input logic e, input logic v,
                         input int d, input logic l, input logic b);
    vec_t t;
    t.m_ready = r;
    t.flush   = f;
    t.rd_en   = e;
    t.valid   = v;
    t.data    = d[7:0];
    t.last    = l;
    t.busy    = b;
    vecs.push_back(t);
  endtask

  task automatic fifo_push(input int w);
    fifo_q.push_back(W'(w));
    fifo_empty = 1'b0;
  endtask

  task automatic expect_beat(input int w, input logic l);
    exp_q.push_back(W'(w));
    exp_last_q.push_back(l);
  endtask

  // Scoreboard: called at edge+5 of every cycle.
  task automatic sb_check();
    logic [W-1:0] w;
    logic         l;
    if (m_valid && m_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL hs_extra: got %0h, expected no handshake (t=%0t)", m_data, $time);
      end else begin
        w = exp_q.pop_front();
        l = exp_last_q.pop_front();
        chk("hs_data", m_data, w);
        chk("hs_last", W'(m_last), W'(l));
      end
    end
  endtask

  // From edge+1 to edge+5.
  task automatic half();
    #4;
  endtask

  // From edge+5 to next edge+1, including the FIFO model.
  task automatic finish_cycle();
    logic popping;
    sb_check();
    #4;
    popping = fifo_rd_en;
    if (popping) begin
      n_cmp++;
      if (fifo_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_empty: got fifo_rd_en=1, expected 0 while empty (t=%0t)", $time);
      end
    end
    @(posedge clk);
    #1;
    if (popping && (fifo_q.size() != 0)) begin
      fifo_rd_data = fifo_q.pop_front();
      pop_count++;
    end else begin
      fifo_rd_data = junk_word;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic tick();
    half();
    finish_cycle();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    fifo_empty = 1'b1;
    #2;
    chk("rst_valid", W'(m_valid), '0);
    chk("rst_rd_en", W'(fifo_rd_en), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_last", W'(m_last), '0);
    chk("rst_data", m_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pop_count = 0;
    hs_count  = 0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      m_ready = vecs[i].m_ready;
      flush   = vecs[i].flush;
      half();
      chk($sformatf("row%0d_rd_en", i), W'(fifo_rd_en), W'(vecs[i].rd_en));
      chk($sformatf("row%0d_valid", i), W'(m_valid), W'(vecs[i].valid));
      chk($sformatf("row%0d_last", i), W'(m_last), W'(vecs[i].last));
      chk($sformatf("row%0d_busy", i), W'(busy), W'(vecs[i].busy));
      if (vecs[i].valid) begin
        chk($sformatf("row%0d_data", i), m_data, W'(vecs[i].data));
      end
      finish_cycle();
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(name, W'(exp_q.size()), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    pop_count = 0;
    hs_count  = 0;
    junk_word = {25{4'hE}};

    // Streaming, ready held high: {ready, flush, rd_en, valid, data, last, busy}
    add_vec(1, 0, 1, 0, 0, 0, 0);  // c0  first pop (word 0)
    add_vec(1, 0, 1, 0, 0, 0, 1);  // c1  word 0 in flight
    add_vec(1, 0, 1, 1, 0, 0, 1);  // c2  word 0 visible two cycles after first pop
    add_vec(1, 0, 1, 1, 1, 0, 1);
    add_vec(1, 0, 1, 1, 2, 0, 1);
    add_vec(1, 0, 1, 1, 3, 1, 1);  // burst end
    add_vec(1, 0, 1, 1, 4, 0, 1);
    add_vec(1, 0, 1, 1, 5, 0, 1);
    add_vec(1, 0, 1, 1, 6, 0, 1);
    add_vec(1, 0, 1, 1, 7, 1, 1);  // burst end, last pop (word 9)
    add_vec(1, 0, 0, 1, 8, 0, 1);  // FIFO empty
    add_vec(1, 0, 0, 1, 9, 0, 1);
    add_vec(1, 0, 0, 0, 0, 0, 0);  // idle
    // Backpressure: ready low for six cycles, then high
    add_vec(0, 0, 1, 0, 0, 0, 0);  // c0  pop word 0
    add_vec(0, 0, 1, 0, 0, 0, 1);  // c1  pop word 1
    add_vec(0, 0, 0, 1, 0, 0, 1);  // c2  occ 1 + in flight: no room
    add_vec(0, 0, 0, 1, 0, 0, 1);  // c3  occ 2
    add_vec(0, 0, 0, 1, 0, 0, 1);
    add_vec(0, 0, 0, 1, 0, 0, 1);  // c5
    add_vec(1, 0, 1, 1, 0, 0, 1);  // c6  release, pop word 2
    add_vec(1, 0, 1, 1, 1, 0, 1);
    add_vec(1, 0, 1, 1, 2, 0, 1);
    add_vec(1, 0, 1, 1, 3, 1, 1);
    add_vec(1, 0, 0, 1, 4, 0, 1);
    add_vec(1, 0, 0, 1, 5, 0, 1);
    add_vec(1, 0, 0, 0, 0, 0, 0);

    rst_n        = 1'b1;
    m_ready      = 1'b0;
    flush        = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = junk_word;

    // ---- 1. reset / idle ----
    #1;
    rst_n = 1'b0;
    #2;
    chk("t1_valid_a", W'(m_valid), '0);
    chk("t1_rd_en_a", W'(fifo_rd_en), '0);
    chk("t1_busy_a", W'(busy), '0);
    #3;
    chk("t1_valid_b", W'(m_valid), '0);
    chk("t1_rd_en_b", W'(fifo_rd_en), '0);
    chk("t1_busy_b", W'(busy), '0);
    chk("t1_data_b", m_data, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
    chk("t1_valid_c", W'(m_valid), '0);
    chk("t1_busy_c", W'(busy), '0);
    chk("t1_no_pop", W'(pop_count), '0);

    // ---- 2. streaming ----
    for (int i = 0; i < 10; i++) begin
      fifo_push(i);
      expect_beat(i, (i == 3) || (i == 7));
    end
    run_rows(0, 13);
    chk("t2_pops", W'(pop_count), W'(10));
    chk("t2_hs", W'(hs_count), W'(10));
    // Burst position is 2 after word 9, so the second next word closes it.
    fifo_push('h20);
    fifo_push('h21);
    expect_beat('h20, 1'b0);
    expect_beat('h21, 1'b1);
    m_ready = 1'b1;
    drain("t2_tail_drained", 12);

    // ---- 3. backpressure ----
    do_reset();
    for (int i = 0; i < 6; i++) begin
      fifo_push(i);
      expect_beat(i, i == 3);
    end
    run_rows(13, 19);
    chk("t3_stall_pops", W'(pop_count), W'(2));
    run_rows(19, 26);
    chk("t3_pops", W'(pop_count), W'(6));
    chk("t3_drained", W'(exp_q.size()), '0);

    // ---- 4. alternating ready ----
    do_reset();
    fifo_push(88);
    fifo_push(11);
    fifo_push(12);
    fifo_push(33);
    expect_beat(88, 1'b0);
    expect_beat(11, 1'b0);
    expect_beat(12, 1'b0);
    expect_beat(33, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      m_ready = i[0];
      half();
      // pops taken minus beats delivered = occ + inflight
      chk("t4_occupancy_le2", W'((pop_count - hs_count) > 2), '0);
      finish_cycle();
    end
    chk("t4_drained", W'(exp_q.size()), '0);
    chk("t4_hs", W'(hs_count), W'(4));

    // ---- 5. flush ----
    do_reset();
    for (int i = 0; i < 8; i++) fifo_push(i);
    expect_beat(0, 1'b0);  // handed off before the flush
    tick();                // c0 pop 0
    tick();                // c1 pop 1
    half();                // c2 occ 1, word 1 in flight
    chk("t5_c2_rd_en", W'(fifo_rd_en), '0);
    chk("t5_c2_data", m_data, W'(0));
    finish_cycle();
    m_ready = 1'b1;        // c3 occ 2: take word 0, pop word 2
    half();
    chk("t5_c3_rd_en", W'(fifo_rd_en), W'(1));
    finish_cycle();
    m_ready = 1'b0;        // c4 word 1 buffered, word 2 in flight
    flush   = 1'b1;
    half();
    chk("t5_flush_rd_en", W'(fifo_rd_en), '0);
    chk("t5_flush_valid", W'(m_valid), W'(1));
    chk("t5_flush_data", m_data, W'(1));
    finish_cycle();
    flush   = 1'b0;
    m_ready = 1'b1;
    expect_beat(3, 1'b0);
    expect_beat(4, 1'b0);
    expect_beat(5, 1'b0);
    expect_beat(6, 1'b1);
    expect_beat(7, 1'b0);
    half();                // c5 everything discarded
    chk("t5_after_valid", W'(m_valid), '0);
    chk("t5_after_busy", W'(busy), '0);
    chk("t5_after_rd_en", W'(fifo_rd_en), W'(1));
    finish_cycle();
    drain("t5_drained", 20);
    chk("t5_pops", W'(pop_count), W'(8));

    // ---- 6. async reset mid-burst ----
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) fifo_push(i);
    expect_beat(0, 1'b0);
    expect_beat(1, 1'b0);
    expect_beat(2, 1'b0);
    expect_beat(3, 1'b1);
    for (int i = 0; i < 6; i++) tick();  // words 0..5 popped, 0..3 delivered
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", W'(m_valid), '0);
    chk("t6_busy", W'(busy), '0);
    chk("t6_rd_en", W'(fifo_rd_en), '0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fifo_rd_data = junk_word;
    // Words 4 and 5 were lost inside the block; the FIFO head is now 6.
    expect_beat(6, 1'b0);
    expect_beat(7, 1'b0);
    expect_beat(8, 1'b0);
    expect_beat(9, 1'b1);
    drain("t6_drained", 20);
    tick();
    tick();
    chk("t6_pops", W'(pop_count), W'(10));
    chk("t6_idle_valid", W'(m_valid), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net in case a sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
